// File: rtl/mem_io_bus_if.sv
// CPU memory-port bus between the CPU (master) and the mem_io_bus slave.
// Ports: mem_cmd/mem_addr/write_data from the CPU; read_data/bus_err back.
interface mem_io_bus_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              bus_err;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, bus_err
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, bus_err
  );
endinterface

// File: rtl/mem_io_bus.sv
// Memory/I-O slave: 256-word RAM, LED register, synchronized switch port.
// Optional MEM_IO_STATS_EN adds read/write counters at 9'h180/9'h181.
module mem_io_bus #(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 9,
  parameter int              RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic             clk,
  input  logic             reset,
  mem_io_bus_if.slave      bus,
  input  logic [7:0]       sw_in,
  output logic [7:0]       led_out
);

  // Handshake: no valid/ready pair. mem_cmd is a request sampled at every
  // rising edge and always accepted; a read's data is in read_data right
  // after the sampling edge, a write lands on that same edge.
  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;
  localparam int         RAM_AW      = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [7:0]        sw_sync1, sw_sync2;

  logic              is_rd, is_wr, is_bad;
  logic              hit_ram, hit_led, hit_sw, hit_rdc, hit_wrc;
  logic              rd_ok, wr_ok, offend;
  logic [DATA_W-1:0] rd_mux;
  logic [RAM_AW-1:0] ram_idx;

`ifdef MEM_IO_STATS_EN
  localparam logic [ADDR_W-1:0] RDC_ADDR = 9'h180;
  localparam logic [ADDR_W-1:0] WRC_ADDR = 9'h181;
  logic [15:0] rd_cnt, wr_cnt;
`endif

  always_comb begin
    is_rd   = (bus.mem_cmd == CMD_READ);
    is_wr   = (bus.mem_cmd == CMD_WRITE);
    is_bad  = (bus.mem_cmd == CMD_ILLEGAL);
    ram_idx = bus.mem_addr[RAM_AW-1:0];
    hit_ram = ~bus.mem_addr[ADDR_W-1];
    hit_led = (bus.mem_addr == LED_ADDR);
    hit_sw  = (bus.mem_addr == SW_ADDR);
    hit_rdc = 1'b0;
    hit_wrc = 1'b0;
`ifdef MEM_IO_STATS_EN
    hit_rdc = (bus.mem_addr == RDC_ADDR);
    hit_wrc = (bus.mem_addr == WRC_ADDR);
`endif
    rd_ok  = is_rd & (hit_ram | hit_led | hit_sw | hit_rdc | hit_wrc);
    wr_ok  = is_wr & (hit_ram | hit_led);
    // Counter writes are clears: not offending, but not counted either.
    offend = is_bad | (is_rd & ~rd_ok) | (is_wr & ~(wr_ok | hit_rdc | hit_wrc));

    rd_mux = '0;
    if (hit_ram)      rd_mux = ram[ram_idx];
    else if (hit_led) rd_mux = {{(DATA_W-8){1'b0}}, led_out};
    else if (hit_sw)  rd_mux = {{(DATA_W-8){1'b0}}, sw_sync2};
`ifdef MEM_IO_STATS_EN
    else if (hit_rdc) rd_mux = rd_cnt;
    else if (hit_wrc) rd_mux = wr_cnt;
`endif
  end

  // RAM has no reset so contents survive it; writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (reset && wr_ok && hit_ram) ram[ram_idx] <= bus.write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_data <= '0;
      bus.bus_err   <= 1'b0;
      led_out       <= 8'h00;
      sw_sync1      <= 8'h00;
      sw_sync2      <= 8'h00;
    end else begin
      sw_sync1    <= sw_in;
      sw_sync2    <= sw_sync1;
      bus.bus_err <= offend;
      if (is_rd) bus.read_data <= rd_ok ? rd_mux : '0;
      if (wr_ok && hit_led) led_out <= bus.write_data[7:0];
    end
  end

`ifdef MEM_IO_STATS_EN
  // Saturating counters; a read of a counter returns its pre-increment value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt <= 16'h0000;
      wr_cnt <= 16'h0000;
    end else begin
      if (is_wr && hit_rdc)               rd_cnt <= 16'h0000;
      else if (rd_ok && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'h0001;
      if (is_wr && hit_wrc)               wr_cnt <= 16'h0000;
      else if (wr_ok && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_mem_io_bus.sv
// Directed, table-driven bench for mem_io_bus plus hand-written sequences
// for reset-during-write and the optional MEM_IO_STATS_EN counters.
module tb_mem_io_bus;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_in;
  logic [7:0] led_out;

  mem_io_bus_if bus ();

  mem_io_bus dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  sw;
    logic [15:0] exp_rd;
    logic [7:0]  exp_led;
    logic        exp_err;
  } vec_t;

  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] X = 2'b11;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one command at a negedge, let one rising edge sample it, return at the next negedge.
  task automatic cycle(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bus.mem_cmd    = cmd;
    bus.mem_addr   = addr;
    bus.write_data = wd;
    @(negedge clk);
  endtask

  task automatic read_chk(input string name, input logic [8:0] addr,
                          input logic [15:0] exp_rd, input logic exp_err);
    cycle(R, addr, 16'h0000);
    exp_q.push_back(exp_rd);
    check({name, " read_data"}, bus.read_data, exp_q.pop_front());
    check({name, " bus_err"}, {15'd0, bus.bus_err}, {15'd0, exp_err});
  endtask

  function automatic void add(input logic [1:0] cmd, input logic [8:0] addr,
                              input logic [15:0] wd, input logic [7:0] sw,
                              input logic [15:0] rd, input logic [7:0] led, input logic err);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wd; v.sw = sw;
    v.exp_rd = rd; v.exp_led = led; v.exp_err = err;
    vecs.push_back(v);
  endfunction

  initial begin
    //  cmd addr    wdata     sw     read_data led    err
    add(W, 9'h005, 16'hBEEF, 8'h00, 16'h0000, 8'h00, 1'b0);
    add(R, 9'h005, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 1'b0);
    add(N, 9'h005, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 1'b0);
    add(W, 9'h100, 16'h12A5, 8'h00, 16'hBEEF, 8'hA5, 1'b0);
    add(R, 9'h100, 16'h0000, 8'h00, 16'h00A5, 8'hA5, 1'b0);
    add(W, 9'h010, 16'h5555, 8'h00, 16'h00A5, 8'hA5, 1'b0);
    add(N, 9'h000, 16'h0000, 8'h3C, 16'h00A5, 8'hA5, 1'b0);
    add(R, 9'h140, 16'h0000, 8'h3C, 16'h0000, 8'hA5, 1'b0);
    add(R, 9'h140, 16'h0000, 8'h3C, 16'h003C, 8'hA5, 1'b0);
    add(R, 9'h1FF, 16'h0000, 8'h3C, 16'h0000, 8'hA5, 1'b1);
    add(X, 9'h010, 16'h9999, 8'h3C, 16'h0000, 8'hA5, 1'b1);
    add(W, 9'h140, 16'hFFFF, 8'h3C, 16'h0000, 8'hA5, 1'b1);
    add(R, 9'h010, 16'h0000, 8'h3C, 16'h5555, 8'hA5, 1'b0);
    add(R, 9'h100, 16'h0000, 8'h3C, 16'h00A5, 8'hA5, 1'b0);
    add(W, 9'h011, 16'h1111, 8'h3C, 16'h00A5, 8'hA5, 1'b0);
    add(R, 9'h010, 16'h0000, 8'h3C, 16'h5555, 8'hA5, 1'b0);
    add(R, 9'h011, 16'h0000, 8'h3C, 16'h1111, 8'hA5, 1'b0);
    add(R, 9'h011, 16'h0000, 8'h3C, 16'h1111, 8'hA5, 1'b0);
    add(W, 9'h1C0, 16'h7777, 8'h3C, 16'h1111, 8'hA5, 1'b1);
    add(W, 9'h020, 16'h1234, 8'h3C, 16'h1111, 8'hA5, 1'b0);
    add(W, 9'h100, 16'h00FF, 8'h3C, 16'h1111, 8'hFF, 1'b0);
    add(R, 9'h020, 16'h0000, 8'h3C, 16'h1234, 8'hFF, 1'b0);
    add(X, 9'h000, 16'h0000, 8'h3C, 16'h1234, 8'hFF, 1'b1);

    // Clock/reset
    reset          = 1'b0;
    sw_in          = 8'h00;
    bus.mem_cmd    = N;
    bus.mem_addr   = 9'h000;
    bus.write_data = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset read_data", bus.read_data, 16'h0000);
    check("reset led_out", {8'h00, led_out}, 16'h0000);
    check("reset bus_err", {15'd0, bus.bus_err}, 16'h0000);
    reset = 1'b1;

    foreach (vecs[i]) begin
      sw_in = vecs[i].sw;
      cycle(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
      exp_q.push_back(vecs[i].exp_rd);
      check($sformatf("v%0d read_data", i), bus.read_data, exp_q.pop_front());
      check($sformatf("v%0d led_out", i), {8'h00, led_out}, {8'h00, vecs[i].exp_led});
      check($sformatf("v%0d bus_err", i), {15'd0, bus.bus_err}, {15'd0, vecs[i].exp_err});
    end

    // Reset asserted mid-cycle with a RAM write pending: outputs clear at once, write dropped.
    bus.mem_cmd    = W;
    bus.mem_addr   = 9'h020;
    bus.write_data = 16'hABCD;
    #2 reset = 1'b0;
    #1;
    check("async reset read_data", bus.read_data, 16'h0000);
    check("async reset led_out", {8'h00, led_out}, 16'h0000);
    check("async reset bus_err", {15'd0, bus.bus_err}, 16'h0000);
    @(negedge clk);
    check("in reset led_out", {8'h00, led_out}, 16'h0000);
    check("in reset read_data", bus.read_data, 16'h0000);
    reset = 1'b1;
    cycle(N, 9'h000, 16'h0000);

`ifdef MEM_IO_STATS_EN
    read_chk("post-reset ram 020 a", 9'h020, 16'h1234, 1'b0);
    read_chk("post-reset ram 020 b", 9'h020, 16'h1234, 1'b0);
    read_chk("post-reset ram 020 c", 9'h020, 16'h1234, 1'b0);
    cycle(W, 9'h030, 16'h0030);
    cycle(W, 9'h031, 16'h0031);
    read_chk("wr_cnt", 9'h181, 16'h0002, 1'b0);
    read_chk("rd_cnt", 9'h180, 16'h0004, 1'b0);
    cycle(W, 9'h180, 16'hFFFF);
    check("rd_cnt clear bus_err", {15'd0, bus.bus_err}, 16'h0000);
    read_chk("rd_cnt after clear", 9'h180, 16'h0000, 1'b0);
    read_chk("wr_cnt unchanged", 9'h181, 16'h0002, 1'b0);
`else
    read_chk("post-reset ram 020", 9'h020, 16'h1234, 1'b0);
    read_chk("unmapped 180", 9'h180, 16'h0000, 1'b1);
    read_chk("unmapped 181", 9'h181, 16'h0000, 1'b1);
`endif
    cycle(N, 9'h000, 16'h0000);
    check("err cleared", {15'd0, bus.bus_err}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
